scoreboard_display: RTL and testbench

Downstream display stage of the basketball scoring system. It consumes the shot-clock, game-timer and score buses, converts each binary field to BCD with one shared sequential converter, and drives a 13-digit time-multiplexed common-anode 7-segment display. All inputs are snapshotted once per scan frame and committed atomically, so a frame never shows a torn value.

---
 rtl/scoreboard_pkg.sv | 27 ++
 rtl/scoreboard_display_bin2bcd.sv | 38 +++
 rtl/scoreboard_display.sv | 129 ++++++++++++
 tb/tb_scoreboard_display.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// scoreboard_pkg: shared constants, digit-slot map, segment decoder and converter states
package scoreboard_pkg;
  localparam int NUM_DIGITS = 13;
  localparam int SLOT_S1 = 0;
  localparam int SLOT_S2 = 3;
  localparam int SLOT_MIN = 6;
  localparam int SLOT_SEC = 8;
  localparam int SLOT_SHOT = 10;
  localparam logic [3:0] BLANK = 4'hF;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, COMMIT} cnv_state_t;
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return SEG_OFF;
    endcase
  endfunction
endpackage

// File: rtl/scoreboard_display_bin2bcd.sv
// bin2bcd_seq: sequential 8-bit double-dabble converter, start to valid digits in 9 cycles
module bin2bcd_seq (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic [7:0] bin,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       done
);
  logic [19:0] sh, adj;
  logic [2:0] cnt;
  logic busy;
  // add 3 to every BCD nibble of 5 or more ahead of the shift; done flags the final shift step
  always_comb begin
    adj = sh;
    for (int i = 0; i < 3; i++)
      adj[8+4*i +: 4] = sh[8+4*i +: 4] >= 4'd5 ? sh[8+4*i +: 4] + 4'd3 : sh[8+4*i +: 4];
    {hund, tens, ones} = sh[19:8];
    done = busy && cnt == 3'd0;
  end
  // load on start, then eight shift-and-add steps
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      sh <= '0;
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      sh <= {12'd0, bin};
      cnt <= 3'd7;
      busy <= 1'b1;
    end else if (busy) begin
      sh <= {adj[18:0], 1'b0};
      cnt <= cnt - 3'd1;
      busy <= cnt != 3'd0;
    end
endmodule

// File: rtl/scoreboard_display.sv
// scoreboard_display: snapshots score/timer buses per frame, converts to BCD, scans 13 7-seg digits
module scoreboard_display
  import scoreboard_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4:0]            shotClock_S,
  input  logic [3:0]            shotClock_dS,
  input  logic [3:0]            timer_M,
  input  logic [5:0]            timer_S,
  input  logic [7:0]            Score1,
  input  logic [7:0]            Score2,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [NUM_DIGITS-1:0] dig_n,
  output logic                  frame_done
);
  localparam int DW = $clog2(SCAN_DIV);
  logic [DW-1:0] div;
  logic [3:0] idx, nidx;
  logic kick, tc, wrap, frame_start, adv, valid;
  logic [NUM_DIGITS-1:0][3:0] disp, frame_buf;
  logic [11:0][3:0] shadow;
  logic [7:0] snap_s1, snap_s2, cnv_in;
  logic [3:0] snap_m, snap_ds;
  logic [5:0] snap_s;
  logic [4:0] snap_sc;
  cnv_state_t state;
  logic [2:0] fld;
  logic [3:0] h, t, o, h_b, t_s, t_b;
  logic cnv_done;

  bin2bcd_seq u_cnv (
    .CLK  (CLK),
    .RST_N(RST_N),
    .start(state == LOAD),
    .bin  (cnv_in),
    .hund (h),
    .tens (t),
    .ones (o),
    .done (cnv_done)
  );

  // slot/frame timing, converter operand select and leading-zero blanking of converted digits
  always_comb begin
    tc = div == DW'(SCAN_DIV - 1);
    wrap = tc && idx == 4'(NUM_DIGITS - 1);
    frame_start = wrap || kick;
    adv = tc || kick;
    nidx = frame_start ? 4'd0 : idx + 4'd1;
    cnv_in = fld == 3'd0 ? snap_s1 : fld == 3'd1 ? snap_s2 : fld == 3'd2 ? {4'd0, snap_m} :
             fld == 3'd3 ? {2'd0, snap_s} : {3'd0, snap_sc};
    h_b = h == 4'd0 ? BLANK : h;
    t_s = (h == 4'd0 && t == 4'd0) ? BLANK : t;
    t_b = t == 4'd0 ? BLANK : t;
  end

  // scanner: frame_buf freezes the committed digits for a whole frame; slot 0 reads disp directly at the wrap
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      div <= '0;
      idx <= '0;
      kick <= 1'b1;
      frame_buf <= '1;
      seg_n <= SEG_OFF;
      dp_n <= 1'b1;
      dig_n <= '1;
      frame_done <= 1'b0;
    end else begin
      kick <= 1'b0;
      div <= adv ? '0 : div + 1'b1;
      idx <= adv ? nidx : idx;
      frame_done <= wrap;
      if (frame_start) frame_buf <= disp;
      if (adv) begin
        seg_n <= seg_decode(frame_start ? disp[0] : frame_buf[nidx]);
        dp_n <= !(nidx == 4'(SLOT_MIN + 1) || nidx == 4'(SLOT_SHOT + 1));
      end
      dig_n <= (!valid || adv) ? '1 : ~(13'(1) << idx);
    end

  // converter FSM: snapshot at frame start, five fields through the shared converter, atomic commit
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      fld <= '0;
      shadow <= '1;
      disp <= '1;
      valid <= 1'b0;
      snap_s1 <= '0;
      snap_s2 <= '0;
      snap_m <= '0;
      snap_s <= '0;
      snap_sc <= '0;
      snap_ds <= '0;
    end else if (frame_start) begin
      snap_s1 <= Score1;
      snap_s2 <= Score2;
      snap_m <= timer_M;
      snap_s <= timer_S;
      snap_sc <= shotClock_S;
      snap_ds <= shotClock_dS;
      fld <= '0;
      state <= LOAD;
    end else
      case (state)
        LOAD: state <= SHIFT;
        SHIFT: state <= cnv_done ? STORE : SHIFT;
        STORE: begin
          case (fld)
            3'd0: shadow[SLOT_S1 +: 3] <= {o, t_s, h_b};
            3'd1: shadow[SLOT_S2 +: 3] <= {o, t_s, h_b};
            3'd2: shadow[SLOT_MIN +: 2] <= {o, t_b};
            3'd3: shadow[SLOT_SEC +: 2] <= {o, t};
            default: shadow[SLOT_SHOT +: 2] <= {o, t_b};
          endcase
          fld <= fld + 3'd1;
          state <= fld == 3'd4 ? COMMIT : LOAD;
        end
        COMMIT: begin
          disp <= {snap_ds, shadow};
          valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_scoreboard_display.sv
// tb_scoreboard_display: table vectors, corner sequences and random frames against a digit-level model
module tb_scoreboard_display;
  localparam int SD = 4;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic [4:0] shotClock_S;
  logic [3:0] shotClock_dS, timer_M;
  logic [5:0] timer_S;
  logic [7:0] Score1, Score2;
  logic [6:0] seg_n;
  logic dp_n, frame_done;
  logic [12:0] dig_n;
  int total = 0, passed = 0;
  int exp_d [13];
  logic [6:0] cap_seg [13];
  logic cap_dp [13];
  logic [6:0] seg_ref [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  typedef struct {
    logic [7:0] s1, s2;
    logic [3:0] m;
    logic [5:0] s;
    logic [4:0] sc;
    logic [3:0] ds;
    logic [103:0] txt;
  } vec_t;
  vec_t vecs [5];

  scoreboard_display #(.SCAN_DIV(SD)) dut (
    .CLK(CLK), .RST_N(RST_N), .shotClock_S(shotClock_S), .shotClock_dS(shotClock_dS),
    .timer_M(timer_M), .timer_S(timer_S), .Score1(Score1), .Score2(Score2),
    .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input int s1, input int s2, input int m, input int s, input int sc, input int ds);
    Score1 = 8'(s1);
    Score2 = 8'(s2);
    timer_M = 4'(m);
    timer_S = 6'(s);
    shotClock_S = 5'(sc);
    shotClock_dS = 4'(ds);
  endtask

  task automatic model(input int s1, input int s2, input int m, input int s, input int sc, input int ds);
    exp_d[0] = s1 < 100 ? -1 : s1 / 100;
    exp_d[1] = s1 < 10 ? -1 : s1 / 10 % 10;
    exp_d[2] = s1 % 10;
    exp_d[3] = s2 < 100 ? -1 : s2 / 100;
    exp_d[4] = s2 < 10 ? -1 : s2 / 10 % 10;
    exp_d[5] = s2 % 10;
    exp_d[6] = m < 10 ? -1 : m / 10;
    exp_d[7] = m % 10;
    exp_d[8] = s / 10;
    exp_d[9] = s % 10;
    exp_d[10] = sc < 10 ? -1 : sc / 10;
    exp_d[11] = sc % 10;
    exp_d[12] = ds;
  endtask

  task automatic from_text(input logic [103:0] txt);
    logic [7:0] c;
    for (int i = 0; i < 13; i++) begin
      c = txt[8*(12-i) +: 8];
      exp_d[i] = c == 8'h20 ? -1 : int'(c) - 48;
    end
  endtask

  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!frame_done && n < 4 * 13 * SD);
    chk("frame_done arrival", frame_done, 1);
  endtask

  task automatic capture();
    int bad = 0;
    logic [12:0] first_bad = '1;
    for (int s = 0; s < 13; s++)
      for (int c = 0; c < SD; c++) begin
        if (s != 0 || c != 0) @(negedge CLK);
        if (c == 0) begin
          cap_seg[s] = seg_n;
          cap_dp[s] = dp_n;
        end
        if (dig_n !== (c == 0 ? 13'h1FFF : ~(13'b1 << s)) || seg_n !== cap_seg[s] ||
            frame_done !== (s == 0 && c == 0)) begin
          if (bad == 0) first_bad = dig_n;
          bad++;
        end
      end
    @(negedge CLK);
    chk("frame period 52", frame_done, 1);
    chk($sformatf("scan cadence, first bad dig_n %h", first_bad), bad, 0);
  endtask

  task automatic compare(input string tag);
    for (int s = 0; s < 13; s++) begin
      chk($sformatf("%s seg slot %0d", tag, s), cap_seg[s], exp_d[s] < 0 ? 7'h7F : seg_ref[exp_d[s]]);
      chk($sformatf("%s dp slot %0d", tag, s), cap_dp[s], (s == 7 || s == 11) ? 1'b0 : 1'b1);
    end
  endtask

  task automatic show(input int s1, input int s2, input int m, input int s, input int sc, input int ds);
    drive(s1, s2, m, s, sc, ds);
    wait_fd();
    wait_fd();
    capture();
    model(s1, s2, m, s, sc, ds);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit idle;
    int r [6];
    vecs[0] = '{8'd123, 8'd0, 4'd0, 6'd0, 5'd0, 4'd0, "123  0 000 00"};
    vecs[1] = '{8'd7, 8'd0, 4'd12, 6'd5, 5'd9, 4'd4, "  7  01205 94"};
    vecs[2] = '{8'd99, 8'd100, 4'd15, 6'd63, 5'd31, 4'd9, " 991001563319"};
    vecs[3] = '{8'd255, 8'd10, 4'd0, 6'd60, 5'd0, 4'd0, "255 10 060 00"};
    vecs[4] = '{8'd0, 8'd205, 4'd9, 6'd59, 5'd10, 4'd1, "  0205 959101"};
    drive(123, 0, 0, 0, 0, 0);
    repeat (3) @(negedge CLK);
    chk("reset seg_n", seg_n, 7'h7F);
    chk("reset dp_n", dp_n, 1);
    chk("reset dig_n", dig_n, 13'h1FFF);
    chk("reset frame_done", frame_done, 0);
    RST_N = 1'b1;
    n = 0;
    idle = 1'b1;
    do begin
      @(negedge CLK);
      n++;
      if (!frame_done && dig_n !== 13'h1FFF) idle = 1'b0;
    end while (!frame_done && n < 80);
    chk("first frame_done after release", frame_done, 1);
    chk("dig_n idle until first commit", idle, 1);
    capture();
    from_text(vecs[0].txt);
    compare("reset_123");
    for (int i = 0; i < 5; i++) begin
      show(vecs[i].s1, vecs[i].s2, vecs[i].m, vecs[i].s, vecs[i].sc, vecs[i].ds);
      from_text(vecs[i].txt);
      compare($sformatf("vec%0d", i));
    end
    show(99, 3, 1, 2, 3, 4);
    compare("tear_base");
    repeat (20) @(negedge CLK);
    drive(100, 3, 1, 2, 3, 4);
    wait_fd();
    capture();
    model(99, 3, 1, 2, 3, 4);
    compare("tear_hold");
    capture();
    model(100, 3, 1, 2, 3, 4);
    compare("tear_new");
    repeat (21) @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("async reset seg_n", seg_n, 7'h7F);
    chk("async reset dp_n", dp_n, 1);
    chk("async reset dig_n", dig_n, 13'h1FFF);
    chk("async reset frame_done", frame_done, 0);
    drive(42, 7, 3, 45, 24, 8);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    wait_fd();
    capture();
    model(42, 7, 3, 45, 24, 8);
    compare("post_reset");
    for (int k = 0; k < 8; k++) begin
      r[0] = int'($urandom_range(255));
      r[1] = int'($urandom_range(255));
      r[2] = int'($urandom_range(15));
      r[3] = int'($urandom_range(63));
      r[4] = int'($urandom_range(31));
      r[5] = int'($urandom_range(9));
      show(r[0], r[1], r[2], r[3], r[4], r[5]);
      compare($sformatf("rand%0d", k));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
